// File: rtl/dma_cpu_mul_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier.
// Op encodings, FSM state enum and the partial-product half width.
package dma_cpu_mul_pkg;

  localparam int HALF_W = 16;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXUU = 2'b01;
  localparam logic [1:0] OP_MULXSS = 2'b10;
  localparam logic [1:0] OP_MULXSU = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PP0,
    S_PP1,
    S_PP2,
    S_PP3,
    S_FIX,
    S_DONE
  } state_t;

endpackage

// File: rtl/dma_cpu_mul_pp16.sv
// Combinational 16x16 unsigned partial-product multiplier.
// Ports: a, b (16-bit halves) -> p (32-bit product).
module dma_cpu_mul_pp16
  import dma_cpu_mul_pkg::*;
(
  input  logic [HALF_W-1:0]   a,
  input  logic [HALF_W-1:0]   b,
  output logic [2*HALF_W-1:0] p
);

  assign p = a * b;

endmodule

// File: rtl/dma_cpu_mul_seq.sv
// Sequential 32x32 multiply unit sharing one 16x16 multiplier.
// Ports: clk, reset (sync, active-high); in_valid/in_ready with
// in_src1, in_src2, in_op; out_valid/out_ready with out_result.
// DMA_CPU_MUL_SEQ_MULX_EN enables the MULX* high-word ops.
module dma_cpu_mul_seq
  import dma_cpu_mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic [1:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result
);

`ifdef DMA_CPU_MUL_SEQ_MULX_EN
  localparam int ACC_W = 64;
`else
  localparam int ACC_W = 32;
`endif

  state_t            state;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  addend;
  logic [ACC_W-1:0]  acc_sum;
  logic [HALF_W-1:0] a_h;
  logic [HALF_W-1:0] b_h;
  logic [31:0]       pp;

`ifdef DMA_CPU_MUL_SEQ_MULX_EN
  logic [1:0]  op_q;
  logic [31:0] sub_b;
  logic [31:0] sub_a;
  logic [31:0] hi_fixed;
`else
  logic unused_op;
  assign unused_op = ^in_op;
`endif

  // High halves of A feed PP2/PP3, high halves of B feed PP1/PP3.
  always_comb begin
    a_h = a_q[15:0];
    b_h = b_q[15:0];
    if (state == S_PP2 || state == S_PP3)
      a_h = a_q[31:16];
    if (state == S_PP1 || state == S_PP3)
      b_h = b_q[31:16];
  end

  dma_cpu_mul_pp16 u_pp (
    .a (a_h),
    .b (b_h),
    .p (pp)
  );

  always_comb begin
    addend = '0;
    case (state)
      S_PP0:        addend = ACC_W'(pp);
      S_PP1, S_PP2: addend = ACC_W'(pp) << HALF_W;
`ifdef DMA_CPU_MUL_SEQ_MULX_EN
      S_PP3:        addend = {pp, 32'b0};
`endif
      default:      addend = '0;
    endcase
  end

  assign acc_sum = acc + addend;

`ifdef DMA_CPU_MUL_SEQ_MULX_EN
  // Two's-complement correction of the unsigned product's high word.
  assign sub_b = (op_q != OP_MULXUU && a_q[31]) ? b_q : 32'd0;
  assign sub_a = (op_q == OP_MULXSS && b_q[31]) ? a_q : 32'd0;
  assign hi_fixed = acc[63:32] - sub_b - sub_a;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      acc        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
`ifdef DMA_CPU_MUL_SEQ_MULX_EN
      op_q       <= OP_MUL;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q      <= in_src1;
            b_q      <= in_src2;
            acc      <= '0;
            in_ready <= 1'b0;
            state    <= S_PP0;
`ifdef DMA_CPU_MUL_SEQ_MULX_EN
            op_q     <= in_op;
`endif
          end
        end
        S_PP0: begin
          acc   <= acc_sum;
          state <= S_PP1;
        end
        S_PP1: begin
          acc   <= acc_sum;
          state <= S_PP2;
        end
        S_PP2: begin
          acc <= acc_sum;
`ifdef DMA_CPU_MUL_SEQ_MULX_EN
          if (op_q == OP_MUL) begin
            out_result <= acc_sum[31:0];
            out_valid  <= 1'b1;
            state      <= S_DONE;
          end else begin
            state <= S_PP3;
          end
`else
          out_result <= acc_sum[31:0];
          out_valid  <= 1'b1;
          state      <= S_DONE;
`endif
        end
`ifdef DMA_CPU_MUL_SEQ_MULX_EN
        S_PP3: begin
          acc   <= acc_sum;
          state <= S_FIX;
        end
        S_FIX: begin
          acc[63:32] <= hi_fixed;
          out_result <= hi_fixed;
          out_valid  <= 1'b1;
          state      <= S_DONE;
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_cpu_mul_seq.sv
// Self-checking bench for dma_cpu_mul_seq.
// Directed cases plus randomized ops against an arithmetic model.
module tb_dma_cpu_mul_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  int vectors = 0;
  int fails   = 0;

  dma_cpu_mul_seq dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] eff_op(input logic [1:0] op);
`ifdef DMA_CPU_MUL_SEQ_MULX_EN
    return op;
`else
    return 2'b00;
`endif
  endfunction

  function automatic int latency(input logic [1:0] op);
    return (eff_op(op) == 2'b00) ? 4 : 6;
  endfunction

  // Reference: full-width signed/unsigned products, then pick a word.
  function automatic logic [31:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0]        p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (eff_op(op))
      2'b00:   p = {32'b0, a} * {32'b0, b};
      2'b01:   p = {32'b0, a} * {32'b0, b};
      2'b10:   p = sa * sb;
      default: p = sa * $signed({32'b0, b});
    endcase
    return (eff_op(op) == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic run_op(input logic [1:0]  op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int          hold);
    int          n;
    logic [31:0] exp;
    exp = model(op, a, b);
    n = 0;
    while (!in_ready && n < 20) begin
      tick;
      n++;
    end
    chk("ready_before_issue", {31'b0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_src1   = a;
    in_src2   = b;
    in_op     = op;
    out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    in_src1  = $urandom;
    in_src2  = $urandom;
    in_op    = 2'($urandom_range(0, 3));
    n = 1;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    chk("latency", 32'(n), 32'(latency(op)));
    chk("busy_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 0);
      in_src1  = $urandom;
      in_src2  = $urandom;
      tick;
      in_valid = 1'b0;
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_ready", {31'b0, in_ready}, 32'd0);
      chk("hold_result", out_result, exp);
    end
    out_ready = 1'b1;
    chk("result", out_result, exp);
    tick;
    out_ready = 1'b0;
    chk("post_valid", {31'b0, out_valid}, 32'd0);
    chk("post_ready", {31'b0, in_ready}, 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_src1   = '0;
    in_src2   = '0;
    in_op     = '0;
    out_ready = 1'b0;
    tick;
    tick;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    reset = 1'b0;
    tick;

    run_op(2'b00, 32'h0001_0003, 32'h0002_0005, 0);
    chk("mul_example", model(2'b00, 32'h0001_0003, 32'h0002_0005),
        32'h000B_000F);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_op(2'b10, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b01, 32'h0001_0003, 32'h0002_0005, 0);
    run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 3);
    run_op(2'b10, 32'h8000_0001, 32'h7FFF_FFFF, 3);

    // Abort mid-operation: accept, then reset while in PP2.
    in_valid = 1'b1;
    in_src1  = 32'hDEAD_BEEF;
    in_src2  = 32'h1357_9BDF;
    in_op    = 2'b10;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_result", out_result, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("abort_quiet", {31'b0, out_valid}, 32'd0);
    end

    for (int i = 0; i < 40; i++)
      run_op(2'($urandom_range(0, 3)), pick(), pick(),
             int'($urandom_range(0, 2)));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

endmodule
